seg_scan_ctrl: RTL and testbench

//  Time-multiplexed controller for a multi-digit, common-anode 7-segment display.

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg_refresh_tick.sv | 26 ++
 rtl/seg_scan_ctrl.sv | 96 +++++++++
 tb/tb_seg_scan_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and the active-low GFEDCBA decoder for the 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] CODE_T     = 4'hA;
  localparam logic [3:0] CODE_R     = 4'hB;
  localparam logic [3:0] CODE_Y     = 4'hC;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Codes A/B/C render the message glyphs t/r/Y rather than hex letters.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h07;
      4'hB:    pat = 7'h2F;
      4'hC:    pat = 7'h11;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_refresh_tick.sv
// Digit-slot prescaler: marks the last cycle of each slot and the anti-ghost blank window at its start.
module seg_refresh_tick #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end,
  output logic blank
);

  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0] r_presc;
  logic          w_wrap;

  assign w_wrap   = (r_presc == PW'(REFRESH_DIV - 1));
  assign slot_end = w_wrap;
  assign blank    = (r_presc < PW'(BLANK_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || w_wrap) r_presc <= '0;
    else               r_presc <= r_presc + PW'(1);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment controller: keypad shift-in digit buffer, scan index and registered an/seg.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              key_valid,
  input  logic [3:0]                        key_code,
  input  logic                              clr,
  input  logic                              msg_try,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [6:0]                        seg,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              full
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [3:0]            r_buf [NUM_DIGITS];
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;

  logic                  w_slot_end;
  logic                  w_blank;
  logic                  w_full;
  logic                  w_accept;
  logic [3:0]            w_nib;
  logic [NUM_DIGITS-1:0] w_an;
  logic [6:0]            w_seg;

  seg_refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .slot_end(w_slot_end),
    .blank   (w_blank)
  );

  assign w_full   = (r_cnt == CW'(NUM_DIGITS));
  assign w_accept = key_valid && !msg_try && (key_code != CODE_BLANK) && !w_full;

  always_comb begin
    w_nib = r_buf[r_idx];
    if (msg_try) begin
      case (r_idx)
        IW'(2):  w_nib = CODE_T;
        IW'(1):  w_nib = CODE_R;
        IW'(0):  w_nib = CODE_Y;
        default: w_nib = CODE_BLANK;
      endcase
    end
    w_an  = '1;
    w_seg = SEG_BLANK;
    if (!w_blank) begin
      w_an  = ~(NUM_DIGITS'(1) << r_idx);
      w_seg = seg_decode(w_nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) r_buf[k] <= CODE_BLANK;
      r_cnt <= '0;
      r_idx <= '0;
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else begin
      if (clr) begin
        for (int unsigned k = 0; k < NUM_DIGITS; k++) r_buf[k] <= CODE_BLANK;
        r_cnt <= '0;
      end else if (w_accept) begin
        for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) r_buf[k] <= r_buf[k-1];
        r_buf[0] <= key_code;
        r_cnt    <= r_cnt + CW'(1);
      end
      if (w_slot_end) r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign digit_count = r_cnt;
  assign full        = w_full;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic checked each cycle against an arithmetic model.
module tb_seg_scan_ctrl;

  localparam int ND  = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'h0;
  logic          clr = 1'b0;
  logic          msg_try = 1'b0;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic [2:0]    digit_count;
  logic          full;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time since reset gives prescaler and scan index directly.
  int         m_t = 0;
  int         m_cnt = 0;
  logic [3:0] m_buf [ND];
  logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h07, 7'h2F, 7'h11, 7'h21, 7'h06, 7'h7F};

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .clr        (clr),
    .msg_try    (msg_try),
    .an         (an),
    .seg        (seg),
    .digit_count(digit_count),
    .full       (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict registered outputs from pre-edge state, update model, compare after the edge.
  task automatic step();
    logic [ND-1:0] e_an;
    logic [6:0]    e_seg;
    logic [3:0]    nib;
    int            p, i, low;
    p = m_t % DIV;
    i = (m_t / DIV) % ND;
    if (rst) begin
      e_an  = '1;
      e_seg = 7'h7F;
      for (int k = 0; k < ND; k++) m_buf[k] = 4'hF;
      m_cnt = 0;
      m_t   = 0;
    end else begin
      if (p < BLK) begin
        e_an  = '1;
        e_seg = 7'h7F;
      end else begin
        e_an = '1;
        e_an[i] = 1'b0;
        if (msg_try) nib = (i == 2) ? 4'hA : (i == 1) ? 4'hB : (i == 0) ? 4'hC : 4'hF;
        else         nib = m_buf[i];
        e_seg = DEC[nib];
      end
      if (clr) begin
        for (int k = 0; k < ND; k++) m_buf[k] = 4'hF;
        m_cnt = 0;
      end else if (key_valid && !msg_try && key_code != 4'hF && m_cnt < ND) begin
        for (int k = ND - 1; k > 0; k--) m_buf[k] = m_buf[k-1];
        m_buf[0] = key_code;
        m_cnt++;
      end
      m_t++;
    end
    @(posedge clk);
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("digit_count", 32'(digit_count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == ND));
    low = 0;
    for (int k = 0; k < ND; k++) if (an[k] === 1'b0) low++;
    chk("an_onehot", 32'(low <= 1), 32'd1);
  endtask

  // Advance until the model says the next edge samples prescaler p in slot i.
  task automatic wait_until(input int i, input int p);
    int n = 0;
    while (!((m_t % DIV) == p && ((m_t / DIV) % ND) == i) && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) begin
      n_tests++;
      n_fail++;
      $error("FAIL wait_slot: observed timeout expected slot %0d presc %0d", i, p);
    end
  endtask

  task automatic key(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    step();
    key_valid = 1'b0;
  endtask

  initial begin
    #2;
    // 1: reset, idle
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_count", 32'(digit_count), 32'd0);
    repeat (40) begin
      step();
      chk("idle_seg", 32'(seg), 32'h7F);
    end

    // 2: keys 1,2,3
    key(4'h1); key(4'h2); key(4'h3);
    chk("count3", 32'(digit_count), 32'd3);
    wait_until(0, 2); step();
    chk("i0_an", 32'(an), 32'b1110);
    chk("i0_seg", 32'(seg), 32'h30);
    wait_until(3, 2); step();
    chk("i3_an", 32'(an), 32'b0111);
    chk("i3_seg", 32'(seg), 32'h7F);

    // 3: fill from empty, overflow key ignored
    clr = 1'b1; step(); clr = 1'b0;
    key(4'h4); key(4'h5); key(4'h6);
    chk("not_full", 32'(full), 32'd0);
    key(4'h7);
    chk("full_rise", 32'(full), 32'd1);
    key(4'h8);
    chk("full_count", 32'(digit_count), 32'd4);
    wait_until(3, 4); step();
    chk("buf3_seg", 32'(seg), 32'h19);
    wait_until(0, 4); step();
    chk("buf0_seg", 32'(seg), 32'h78);

    // 4: clr beats key; blank code ignored
    key_valid = 1'b1; key_code = 4'h9; clr = 1'b1;
    step();
    key_valid = 1'b0; clr = 1'b0;
    chk("clr_count", 32'(digit_count), 32'd0);
    chk("clr_full", 32'(full), 32'd0);
    key(4'hF);
    chk("keyF_count", 32'(digit_count), 32'd0);

    // 5: message override
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    msg_try = 1'b1;
    wait_until(0, 2); step(); chk("msg_i0", 32'(seg), 32'h11);
    key(4'h5);
    wait_until(1, 2); step(); chk("msg_i1", 32'(seg), 32'h2F);
    wait_until(2, 2); step(); chk("msg_i2", 32'(seg), 32'h07);
    wait_until(3, 2); step(); chk("msg_i3", 32'(seg), 32'h7F);
    msg_try = 1'b0;
    wait_until(0, 2); step(); chk("buf_i0", 32'(seg), 32'h19);
    wait_until(1, 2); step(); chk("buf_i1", 32'(seg), 32'h30);
    wait_until(2, 2); step(); chk("buf_i2", 32'(seg), 32'h24);
    wait_until(3, 2); step(); chk("buf_i3", 32'(seg), 32'h79);

    // 6: reset mid-scan
    wait_until(2, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_count", 32'(digit_count), 32'd0);
    step(); chk("post_rst1_an", 32'(an), 32'hF);
    step(); chk("post_rst2_an", 32'(an), 32'hF);
    step(); chk("post_rst3_an", 32'(an), 32'b1110);

    // Random traffic
    repeat (800) begin
      rst       = ($urandom_range(0, 199) == 0);
      clr       = ($urandom_range(0, 39) == 0);
      key_valid = ($urandom_range(0, 2) == 0);
      key_code  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) msg_try = ~msg_try;
      step();
    end
    rst = 1'b0; clr = 1'b0; key_valid = 1'b0; msg_try = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
